// File: rtl/shift_seq_ctrl_pkg.sv
// Shared encodings for the multicycle shift sequencer: shift ops,
// shift-amount sources and the sequencer state type.
package shift_seq_pkg;

  localparam logic [1:0] SH_SLL = 2'b00;
  localparam logic [1:0] SH_SRL = 2'b01;
  localparam logic [1:0] SH_SRA = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  // Any source code with bit 1 set selects the memory-derived amount.
  localparam logic [1:0] AMT_RT    = 2'b00;
  localparam logic [1:0] AMT_SHAMT = 2'b01;
  localparam logic [1:0] AMT_MEM   = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOAD  = 2'b01,
    SHIFT = 2'b10,
    DONE  = 2'b11
  } state_t;

endpackage

// File: rtl/shift_seq_ctrl_step.sv
// Single-bit shift of a WIDTH-bit value; the sequencer applies this once
// per cycle to build up multi-bit shifts.
module shift_step
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] value,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] stepped
);

  // Pick the one-position shift for the requested operation.
  always_comb begin
    stepped = value;
    case (op)
      SH_SLL:  stepped = {value[WIDTH-2:0], 1'b0};
      SH_SRL:  stepped = {1'b0, value[WIDTH-1:1]};
      SH_SRA:  stepped = {value[WIDTH-1], value[WIDTH-1:1]};
      SH_ROR:  stepped = {value[0], value[WIDTH-1:1]};
      default: stepped = value;
    endcase
  end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Multicycle shift sequencer: steers the external amount mux, loads the
// operand and amount, shifts one bit per cycle and pulses done.
// Every output is a register, so no input reaches an output combinationally.
module shift_seq_ctrl
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int AMT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       shift_op,
  input  logic [1:0]       amt_src,
  output logic [1:0]       shift_amt_sel,
  input  logic [AMT_W-1:0] n_in,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done
);

  state_t           state;
  logic [AMT_W-1:0] count;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] step_out;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .value   (result),
    .op      (op_q),
    .stepped (step_out)
  );

  // Sequencer FSM; the amount-mux selector register doubles as the captured
  // source and is held for the whole busy window, then cleared on return to IDLE.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      result        <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      shift_amt_sel <= AMT_RT;
      count         <= '0;
      op_q          <= SH_SLL;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_q          <= shift_op;
            shift_amt_sel <= amt_src;
            busy          <= 1'b1;
            state         <= LOAD;
          end
        end
        LOAD: begin
          result <= data_in;
          count  <= n_in;
          if (n_in != '0) begin
            state <= SHIFT;
          end else begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        SHIFT: begin
          result <= step_out;
          count  <= count - AMT_W'(1);
          if (count == AMT_W'(1)) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          busy          <= 1'b0;
          shift_amt_sel <= AMT_RT;
          state         <= IDLE;
        end
        default: begin
          busy          <= 1'b0;
          shift_amt_sel <= AMT_RT;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed self-checking bench for shift_seq_ctrl: reset, each shift op,
// zero and maximum amounts, ignored mid-shift starts and back-to-back ops.
module tb_shift_seq_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  shift_op;
  logic [1:0]  amt_src;
  logic [1:0]  shift_amt_sel;
  logic [4:0]  n_in;
  logic [31:0] data_in;
  logic [31:0] result;
  logic        busy;
  logic        done;

  int n_cmp;
  int n_err;

  shift_seq_ctrl #(.WIDTH(32), .AMT_W(5)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .shift_op      (shift_op),
    .amt_src       (amt_src),
    .shift_amt_sel (shift_amt_sel),
    .n_in          (n_in),
    .data_in       (data_in),
    .result        (result),
    .busy          (busy),
    .done          (done)
  );

  // 10 ns free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reset state, then a reset that lands in the middle of a 20-step shift.
  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (result !== 32'h0) begin n_err++; $display("[TB] FAIL reset_result got %h want %h", result, 32'h0); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("[TB] FAIL reset_done got %b want 0", done); end
    n_cmp++; if (shift_amt_sel !== 2'b00) begin n_err++; $display("[TB] FAIL reset_sel got %b want 00", shift_amt_sel); end
    reset    = 1'b1;
    shift_op = 2'b00;
    amt_src  = 2'b01;
    n_in     = 5'd20;
    data_in  = 32'h0000_000F;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("[TB] FAIL midshift_busy got %b want 1", busy); end
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (result !== 32'h0) begin n_err++; $display("[TB] FAIL midreset_result got %h want %h", result, 32'h0); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL midreset_busy got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("[TB] FAIL midreset_done got %b want 0", done); end
    n_cmp++; if (shift_amt_sel !== 2'b00) begin n_err++; $display("[TB] FAIL midreset_sel got %b want 00", shift_amt_sel); end
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0 || result !== 32'h0) begin n_err++; $display("[TB] FAIL postreset_idle got busy=%b result=%h want busy=0 result=0", busy, result); end
  endtask

  // One complete operation: start sampled in cycle 0, operand/amount
  // scrambled after LOAD, optional start pulse at cycle pulse_at.
  task automatic run_op(input string name, input logic [1:0] op, input logic [1:0] src,
                        input logic [4:0] n, input logic [31:0] data, input logic [31:0] exp_res,
                        input int exp_cyc, input int pulse_at);
    int cyc;
    shift_op = op;
    amt_src  = src;
    n_in     = n;
    data_in  = data;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc   = 1;
    n_cmp++; if (shift_amt_sel !== src) begin n_err++; $display("[TB] FAIL %s_load_sel got %b want %b", name, shift_amt_sel, src); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("[TB] FAIL %s_load_busy got %b want 1", name, busy); end
    while (done !== 1'b1 && cyc < 60) begin
      start = (cyc == pulse_at);
      @(posedge clk); #1;
      cyc++;
      if (cyc == 2) begin
        data_in = ~data;
        n_in    = 5'(n + 5'd3);
      end
    end
    start = 1'b0;
    n_cmp++; if (cyc !== exp_cyc) begin n_err++; $display("[TB] FAIL %s_done_cycle got %0d want %0d", name, cyc, exp_cyc); end
    n_cmp++; if (result !== exp_res) begin n_err++; $display("[TB] FAIL %s_result got %h want %h", name, result, exp_res); end
    @(posedge clk); #1;
    n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin n_err++; $display("[TB] FAIL %s_after_done got done=%b busy=%b want 0 0", name, done, busy); end
    n_cmp++; if (shift_amt_sel !== 2'b00) begin n_err++; $display("[TB] FAIL %s_idle_sel got %b want 00", name, shift_amt_sel); end
    n_cmp++; if (result !== exp_res) begin n_err++; $display("[TB] FAIL %s_hold got %h want %h", name, result, exp_res); end
  endtask

  task automatic test_sll();
    run_op("sll", 2'b00, 2'b01, 5'd4, 32'h0000_0001, 32'h0000_0010, 6, -1);
  endtask

  task automatic test_sra_max();
    run_op("sra31", 2'b10, 2'b00, 5'd31, 32'h8000_0000, 32'hFFFF_FFFF, 33, -1);
  endtask

  task automatic test_srl_ror();
    run_op("srl1", 2'b01, 2'b01, 5'd1, 32'h8000_0001, 32'h4000_0000, 3, -1);
    run_op("ror1", 2'b11, 2'b01, 5'd1, 32'h8000_0001, 32'hC000_0000, 3, -1);
  endtask

  task automatic test_n_zero();
    run_op("nzero", 2'b00, 2'b10, 5'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 2, -1);
  endtask

  // A start pulse during SHIFT must neither disturb the op nor be queued.
  task automatic test_midshift_start();
    run_op("pulse", 2'b01, 2'b00, 5'd5, 32'h0000_0100, 32'h0000_0008, 7, 3);
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("[TB] FAIL pulse_not_queued got busy=%b done=%b want 0 0", busy, done); end
  endtask

  // start held high: each op restarts one IDLE cycle after its done pulse,
  // giving a five-cycle period for N=2 (done at cycles 4, 9, 14).
  task automatic test_back_to_back();
    logic exp_done;
    logic exp_busy;
    shift_op = 2'b00;
    amt_src  = 2'b01;
    n_in     = 5'd2;
    data_in  = 32'h0000_0003;
    start    = 1'b1;
    @(posedge clk); #1;
    for (int c = 1; c <= 15; c++) begin
      exp_done = (c == 4) || (c == 9) || (c == 14);
      exp_busy = (c % 5) != 0;
      n_cmp++; if (done !== exp_done) begin n_err++; $display("[TB] FAIL b2b_done_c%0d got %b want %b", c, done, exp_done); end
      n_cmp++; if (busy !== exp_busy) begin n_err++; $display("[TB] FAIL b2b_busy_c%0d got %b want %b", c, busy, exp_busy); end
      if (exp_done) begin
        n_cmp++; if (result !== 32'h0000_000C) begin n_err++; $display("[TB] FAIL b2b_result_c%0d got %h want %h", c, result, 32'h0000_000C); end
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    repeat (8) @(posedge clk);
  endtask

  // Run every scenario in order, then report.
  initial begin
    n_cmp    = 0;
    n_err    = 0;
    reset    = 1'b0;
    start    = 1'b0;
    shift_op = 2'b00;
    amt_src  = 2'b00;
    n_in     = 5'd0;
    data_in  = 32'h0;
    test_reset();
    test_sll();
    test_sra_max();
    test_srl_ror();
    test_n_zero();
    test_midshift_start();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
